// File: rtl/rtc_bus_reader.sv
// Sweeps nine RTC chip registers over a req/done bus and copies each byte into the
// RTC register memory through its whileT/ADD1/DAT1/w1 write port.
module rtc_bus_reader #(
    parameter logic [7:0]  ADDR_CLK = 8'h21,
    parameter logic [7:0]  ADDR_TMR = 8'h41,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       bus_req,
    output logic [7:0] bus_addr,
    input  logic [7:0] bus_rdata,
    input  logic       bus_done,
    output logic       mem_window,
    output logic [3:0] mem_add,
    output logic [7:0] mem_dat,
    output logic       mem_we,
    input  logic       mem_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, OPEN, REQ, WRITE, NEXT, CLOSE, DONE} state_t;

    localparam logic [9:0] TMAX = 10'(TIMEOUT);

    state_t     state;
    logic [3:0] idx;
    logic [9:0] tcnt;

    function automatic logic [7:0] addr_of(input logic [3:0] i);
        return (i < 4'd6) ? ADDR_CLK + {4'd0, i} : ADDR_TMR + {4'd0, i - 4'd6};
    endfunction

    function automatic logic [3:0] slot_of(input logic [3:0] i);
        return (i < 4'd6) ? i : i + 4'd3;
    endfunction

    // All outputs are registered, so each one is set on the transition into the
    // state that owns it; this keeps window/we strictly inside OPEN..NEXT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_addr   <= 8'd0;
            mem_window <= 1'b0;
            mem_we     <= 1'b0;
            mem_add    <= 4'd15;
            mem_dat    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            idx        <= 4'd0;
            tcnt       <= 10'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= OPEN;
                    busy       <= 1'b1;
                    mem_window <= 1'b1;
                    idx        <= 4'd0;
                    tcnt       <= 10'd0;
                end
                OPEN: begin
                    state    <= REQ;
                    bus_req  <= 1'b1;
                    bus_addr <= addr_of(4'd0);
                end
                REQ: begin
                    tcnt <= tcnt + 10'd1;
                    if (bus_done) begin
                        bus_req <= 1'b0;
                        mem_we  <= 1'b1;
                        mem_add <= slot_of(idx);
                        mem_dat <= bus_rdata;
                        state   <= WRITE;
                    end else if (tcnt == TMAX) begin
                        bus_req <= 1'b0;
                        error   <= 1'b1;
                        state   <= NEXT;
                    end
                end
                WRITE: begin
                    mem_we  <= 1'b0;
                    mem_add <= 4'd15;
                    mem_dat <= 8'd0;
                    state   <= NEXT;
                end
                NEXT: begin
                    tcnt <= 10'd0;
                    if (idx == 4'd8) begin
                        mem_window <= 1'b0;
                        state      <= CLOSE;
                    end else begin
                        idx      <= idx + 4'd1;
                        bus_req  <= 1'b1;
                        bus_addr <= addr_of(idx + 4'd1);
                        state    <= REQ;
                    end
                end
                CLOSE: begin
                    tcnt <= tcnt + 10'd1;
                    // tcnt==0 marks the entry cycle, whose mem_ready level predates the close
                    if (mem_ready && tcnt != 10'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (tcnt == TMAX) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: table of sweep scenarios with hand-computed
// latencies plus hand sequences for reset and power-on state.
module tb_rtc_bus_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bus_req;
    logic [7:0] bus_addr;
    logic [7:0] bus_rdata;
    logic       bus_done;
    logic       mem_window;
    logic [3:0] mem_add;
    logic [7:0] mem_dat;
    logic       mem_we;
    logic       mem_ready;
    logic       busy;
    logic       done;
    logic       error;

    rtc_bus_reader dut (
        .clk(clk), .reset(reset), .start(start),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_done(bus_done),
        .mem_window(mem_window), .mem_add(mem_add), .mem_dat(mem_dat), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          d;          // bus_done delay for ordinary indices, -1 = never
        int          slow_idx;   // index using slow_delay instead, -1 = none
        int          slow_delay;
        int          r;          // mem_ready delay from close entry, -1 = never
        bit          restart;
        int          exp_lat;    // posedge count from OPEN entry to done pulse
        bit          exp_err;
        logic [15:0] exp_mask;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int d_all = -1, slow_idx = -1, slow_delay = 0, ready_delay = -1;

    int          done_cnt, data_err, viol;
    logic [15:0] written;
    logic [7:0]  addr_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int addr_idx(input logic [7:0] a);
        if (a >= 8'h21 && a <= 8'h26) return int'(a - 8'h21);
        if (a >= 8'h41 && a <= 8'h43) return int'(a - 8'h41) + 6;
        return 99;
    endfunction

    function automatic logic [7:0] exp_data(input logic [3:0] slot);
        return (slot < 4'd6) ? 8'h10 + {4'd0, slot} : 8'h10 + {4'd0, slot} - 8'd3;
    endfunction

    // RTC bus responder
    initial begin
        int rcnt;
        int i;
        int dl;
        bus_done  = 1'b0;
        bus_rdata = 8'd0;
        rcnt      = 0;
        forever begin
            @(negedge clk);
            bus_done = 1'b0;
            if (bus_req && !reset) begin
                i  = addr_idx(bus_addr);
                dl = (i == slow_idx) ? slow_delay : d_all;
                if (dl >= 0 && rcnt == dl) begin
                    bus_done  = 1'b1;
                    bus_rdata = 8'h10 + 8'(i);
                end
                rcnt++;
            end else begin
                rcnt = 0;
            end
        end
    end

    // Memory actready model: level rises ready_delay cycles after the window drops
    initial begin
        int   ccnt;
        logic win_prev;
        ccnt      = -1;
        win_prev  = 1'b0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_window)    ccnt = -1;
            else if (win_prev) ccnt = 0;
            else if (ccnt >= 0) ccnt++;
            win_prev  = mem_window;
            mem_ready = (ccnt >= 0) && (ready_delay >= 0) && (ccnt >= ready_delay);
        end
    end

    // Protocol monitor
    initial begin
        logic       req_prev;
        logic [7:0] addr_prev;
        req_prev  = 1'b0;
        addr_prev = 8'd0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mem_we) begin
                written[mem_add] = 1'b1;
                if (mem_dat != exp_data(mem_add)) data_err++;
                if (!mem_window) viol++;
            end else if (mem_add != 4'd15 || mem_dat != 8'd0) begin
                viol++;
            end
            if (bus_req && !req_prev) addr_q.push_back(bus_addr);
            if (bus_req && req_prev && bus_addr != addr_prev) viol++;
            req_prev  = bus_req;
            addr_prev = bus_addr;
        end
    end

    task automatic clear_mon();
        done_cnt = 0;
        data_err = 0;
        viol     = 0;
        written  = 16'd0;
        addr_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req"},  int'(bus_req), 0);
        check({tag, "_bus_addr"}, int'(bus_addr), 0);
        check({tag, "_window"},   int'(mem_window), 0);
        check({tag, "_we"},       int'(mem_we), 0);
        check({tag, "_add"},      int'(mem_add), 15);
        check({tag, "_dat"},      int'(mem_dat), 0);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_done"},     int'(done), 0);
        check({tag, "_error"},    int'(error), 0);
    endtask

    initial begin
        vec_t       vecs[8];
        logic [7:0] exp_addr[9];
        int         t0;
        int         lat;
        bit         seen;
        int         seq_ok;

        vecs[0] = '{0, -1, 0,    1,  1'b0, 30,   1'b0, 16'h0E3F};
        vecs[1] = '{2, -1, 0,    3,  1'b1, 50,   1'b0, 16'h0E3F};
        vecs[2] = '{1,  3, -1,   1,  1'b0, 1060, 1'b1, 16'h0E37};
        vecs[3] = '{0, -1, 0,    -1, 1'b0, 1052, 1'b1, 16'h0E3F};
        vecs[4] = '{0, -1, 0,    20, 1'b0, 49,   1'b0, 16'h0E3F};
        vecs[5] = '{0,  5, 1023, 1,  1'b0, 1053, 1'b0, 16'h0E3F};
        vecs[6] = '{0,  8, 1022, 1,  1'b0, 1052, 1'b0, 16'h0E3F};
        vecs[7] = '{0, -1, 0,    0,  1'b0, 30,   1'b0, 16'h0E3F};
        exp_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

        reset = 1'b1;
        start = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Reset held 3 cycles in the middle of a stalled REQ
        d_all = -1; slow_idx = -1; ready_delay = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("midreq_req_before", int'(bus_req), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreq");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (5) @(negedge clk);
        check("midreq_req_after", int'(bus_req), 0);
        check("midreq_busy_after", int'(busy), 0);
        check("midreq_no_done", done_cnt, 0);

        foreach (vecs[v]) begin
            do_reset();
            d_all       = vecs[v].d;
            slow_idx    = vecs[v].slow_idx;
            slow_delay  = vecs[v].slow_delay;
            ready_delay = vecs[v].r;
            clear_mon();
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            t0   = cyc;
            seen = 1'b0;
            for (int k = 0; k < 3000 && !seen; k++) begin
                if (vecs[v].restart && k == 10) start = 1'b1;
                else start = 1'b0;
                if (done) seen = 1'b1;
                else @(negedge clk);
            end
            start = 1'b0;
            lat = cyc - t0;
            check($sformatf("v%0d_done_seen", v), int'(seen), 1);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_error", v), int'(error), int'(vecs[v].exp_err));
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_done_count", v), done_cnt, 1);
            check($sformatf("v%0d_slot_mask", v), int'(written), int'(vecs[v].exp_mask));
            check($sformatf("v%0d_data_err", v), data_err, 0);
            check($sformatf("v%0d_proto_viol", v), viol, 0);
            check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
            seq_ok = (addr_q.size() == 9) ? 1 : 0;
            if (seq_ok == 1)
                for (int j = 0; j < 9; j++)
                    if (addr_q[j] != exp_addr[j]) seq_ok = 0;
            check($sformatf("v%0d_addr_seq(n=%0d)", v, addr_q.size()), seq_ok, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
